// File: rtl/float_defs_pkg.sv
// float_defs: shared constants for the single-precision FP datapath.
//   FP_EXP_W / FP_MANT_W : default field widths (IEEE-754 single)
//   EXP_MAX              : all-ones exponent used for infinity
//   INF_FRAC / ZERO_FRAC : fraction patterns for infinity and zero
//   ST_*                 : normalize/round FSM state encoding
package float_defs;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [22:0] INF_FRAC  = 23'h0;
    localparam logic [22:0] ZERO_FRAC = 23'h0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;
endpackage

// File: rtl/float_normalize_round.sv
// float_normalize_round: post-add normalize / round-to-nearest-even / pack stage.
// Iterative: one normalize shift per cycle, then one round cycle, then the result
// is held until the consumer takes it.
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   in_valid / in_ready             input handshake (ready only while idle)
//   in_sign, in_exp, in_mant        raw adder result; in_mant = {carry, hidden, fraction}
//   in_guard, in_sticky             bits shifted out by upstream alignment
//   out_valid / out_ready           output handshake; result held while valid
//   out_result                      packed {sign, exp, frac}
//   out_ovf, out_unf, out_zero      saturated-to-inf, flushed-to-zero, magnitude zero
module float_normalize_round
    import float_defs::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W+1:0]       in_mant,
    input  logic                    in_guard,
    input  logic                    in_sticky,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_result,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_zero
);
    localparam int RES_W = EXP_W + MANT_W + 1;

    logic [1:0]          r_state;
    logic                r_sign;
    logic [EXP_W:0]      r_exp;      // one extra bit so overflow past all-ones is visible
    logic [MANT_W+1:0]   r_mant;
    logic                r_guard;
    logic                r_sticky;
    logic [RES_W-1:0]    r_result;
    logic                r_ovf;
    logic                r_unf;
    logic                r_zero;
    logic                r_out_valid;
    logic [RES_W:0]      w_rnd;      // {ovf, packed result}

    // Round to nearest-even, renormalize a rounding carry, saturate to infinity.
    function automatic logic [RES_W:0] f_round(
        input logic              sign,
        input logic [EXP_W:0]    exp_i,
        input logic [MANT_W+1:0] mant,
        input logic              g,
        input logic              s
    );
        logic              inc;
        logic [MANT_W+1:0] sum;
        logic [EXP_W:0]    e;
        inc = g & (s | mant[0]);
        sum = mant + {{(MANT_W+1){1'b0}}, inc};
        e   = exp_i;
        if (sum[MANT_W+1]) begin
            sum = sum >> 1;
            e   = e + 1'b1;
        end
        if (e >= {1'b0, {EXP_W{1'b1}}})
            f_round = {1'b1, sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else
            f_round = {1'b0, sign, e[EXP_W-1:0], sum[MANT_W-1:0]};
    endfunction

    assign w_rnd = f_round(r_sign, r_exp, r_mant, r_guard, r_sticky);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign   <= in_sign;
                        r_exp    <= {1'b0, in_exp};
                        r_mant   <= in_mant;
                        r_guard  <= in_guard;
                        r_sticky <= in_sticky;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_zero   <= 1'b0;
                        r_state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_mant == '0) begin
                        // exact cancellation: positive zero, guard/sticky irrelevant
                        r_result    <= '0;
                        r_zero      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else if (r_mant[MANT_W+1]) begin
                        r_sticky <= r_sticky | r_guard;
                        r_guard  <= r_mant[0];
                        r_mant   <= r_mant >> 1;
                        r_exp    <= r_exp + 1'b1;
                        r_state  <= ST_ROUND;
                    end else if (r_mant[MANT_W]) begin
                        r_state <= ST_ROUND;
                    end else if (r_exp <= (EXP_W+1)'(1)) begin
                        // would go subnormal: flush to signed zero
                        r_result    <= {r_sign, {(RES_W-1){1'b0}}};
                        r_unf       <= 1'b1;
                        r_zero      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_mant  <= {r_mant[MANT_W:0], r_guard};
                        r_guard <= 1'b0;
                        r_exp   <= r_exp - 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_result    <= w_rnd[RES_W-1:0];
                    r_ovf       <= w_rnd[RES_W];
                    r_zero      <= (w_rnd[RES_W-2:0] == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_ovf    = r_ovf;
    assign out_unf    = r_unf;
    assign out_zero   = r_zero;
endmodule

// File: tb/tb_float_normalize_round.sv
module tb_float_normalize_round;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_guard, in_sticky;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid, out_ready, out_ovf, out_unf, out_zero;
    logic [31:0] out_result;

    float_normalize_round dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_guard(in_guard), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic        g, s;
        logic [31:0] res;
        logic        ovf, unf, zero;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf, unf, zero;
        int          lat;
    } exp_t;

    vec_t vt[13];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic sg, logic [7:0] e, logic [24:0] m, logic g, logic s,
                                logic [31:0] r, logic ov, logic un, logic z, int l);
        vec_t v;
        v.sign = sg; v.exp = e; v.mant = m; v.g = g; v.s = s;
        v.res = r; v.ovf = ov; v.unf = un; v.zero = z; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
        in_guard = v.g; in_sticky = v.s; in_valid = 1'b1;
        e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.zero = v.zero; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept_busy", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic collect(input string nm);
        exp_t e;
        int   lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no out_valid want valid", nm);
        end else begin
            chk({nm, "_res"},  out_result, e.res);
            chk({nm, "_ovf"},  {31'b0, out_ovf},  {31'b0, e.ovf});
            chk({nm, "_unf"},  {31'b0, out_unf},  {31'b0, e.unf});
            chk({nm, "_zero"}, {31'b0, out_zero}, {31'b0, e.zero});
            chk({nm, "_lat"},  lat, e.lat);
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_drop"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic stable;
        logic [31:0] held;

        //           sg  exp    mant        g  s  result        ov un z  lat
        vt[0]  = mk(0, 8'h7F, 25'h1800000, 0, 0, 32'h40400000, 0, 0, 0, 2);  // carry path
        vt[1]  = mk(0, 8'h7F, 25'h0000001, 0, 0, 32'h34000000, 0, 0, 0, 25); // 23 left shifts
        vt[2]  = mk(0, 8'h7F, 25'h0800001, 1, 0, 32'h3F800002, 0, 0, 0, 2);  // tie, odd -> up
        vt[3]  = mk(0, 8'h7F, 25'h0800000, 1, 0, 32'h3F800000, 0, 0, 0, 2);  // tie, even -> stay
        vt[4]  = mk(0, 8'hFE, 25'h0FFFFFF, 1, 0, 32'h7F800000, 1, 0, 0, 2);  // round carry overflow
        vt[5]  = mk(1, 8'h02, 25'h0200000, 0, 0, 32'h80000000, 0, 1, 1, 2);  // flush to zero
        vt[6]  = mk(0, 8'h55, 25'h0000000, 1, 1, 32'h00000000, 0, 0, 1, 1);  // exact zero
        vt[7]  = mk(0, 8'h7F, 25'h0800000, 1, 1, 32'h3F800001, 0, 0, 0, 2);  // above half -> up
        vt[8]  = mk(0, 8'h7F, 25'h1800003, 0, 0, 32'h40400002, 0, 0, 0, 2);  // shifted-out bit rounds
        vt[9]  = mk(0, 8'h7F, 25'h0FFFFFF, 1, 0, 32'h40000000, 0, 0, 0, 2);  // round carry renorm
        vt[10] = mk(0, 8'h80, 25'h0400000, 1, 0, 32'h3F800001, 0, 0, 0, 3);  // guard shifted in
        vt[11] = mk(1, 8'h81, 25'h0A00000, 0, 0, 32'hC0A00000, 0, 0, 0, 2);  // negative normal
        vt[12] = mk(0, 8'hFF, 25'h1000000, 0, 0, 32'h7F800000, 1, 0, 0, 2);  // right shift overflow

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_guard = 1'b0; in_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_outs", {out_result, out_valid, out_ovf, out_unf, out_zero} == '0 ? 32'd0 : 32'd1, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            issue(vt[i]);
            collect($sformatf("vec%0d", i));
            release_out($sformatf("vec%0d", i));
        end

        // hold result under backpressure while in_valid is asserted
        issue(vt[11]);
        collect("hold");
        held = out_result;
        stable = 1'b1;
        in_sign = 1'b0; in_exp = 8'h10; in_mant = 25'h1FFFFFF; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_result !== held) stable = 1'b0;
        end
        chk("hold_stable", {31'b0, stable}, 32'd1);
        in_valid = 1'b0;
        release_out("hold");
        issue(vt[2]);
        collect("after_hold");
        release_out("after_hold");

        // reset during normalization abandons the op
        issue(vt[1]);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        void'(sb.pop_front());
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        issue(vt[0]);
        collect("after_rst");
        release_out("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
